// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages, one transaction in flight
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fe_req,
  input  logic [ADDR_W-1:0] i_fe_addr,
  output logic [DATA_W-1:0] o_fe_rdata,
  output logic              o_fe_ack,
  input  logic              i_mem_req,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_mem_we,
  input  logic [2:0]        i_mem_size,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ack,
  input  logic              i_flush,
  output logic              o_bus_v,
  output logic              o_bus_we,
  output logic [2:0]        o_bus_size,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_ready
);
  typedef enum logic [1:0] {IDLE, FE_BUSY, MEM_BUSY} state_t;
  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);
  state_t r_state, w_state_nx;
  logic r_bus_v, r_bus_we, r_fe_ack, r_mem_ack, r_cancel;
  logic [2:0] r_bus_size;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata, r_fe_rdata, r_mem_rdata;
  logic [3:0] r_run_cnt;
  logic w_idle, w_mem_el, w_fe_el, w_fe_grant, w_mem_grant, w_fe_done, w_mem_done, w_fe_deliver;
  // A requester acked this cycle is masked so its still-high request is not granted twice
  always_comb begin
    w_idle       = r_state == IDLE;
    w_mem_el     = i_mem_req && !r_mem_ack;
    w_fe_el      = i_fe_req && !r_fe_ack && !i_flush;
    w_fe_grant   = w_idle && w_fe_el && (!w_mem_el || r_run_cnt == MAX_RUN);
    w_mem_grant  = w_idle && w_mem_el && !w_fe_grant;
    w_fe_done    = r_state == FE_BUSY && i_bus_ready;
    w_mem_done   = r_state == MEM_BUSY && i_bus_ready;
    w_fe_deliver = w_fe_done && !(r_cancel || i_flush);
    w_state_nx   = w_fe_grant ? FE_BUSY : w_mem_grant ? MEM_BUSY :
                   (w_fe_done || w_mem_done) ? IDLE : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bus_v     <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_size  <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_fe_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_fe_rdata  <= '0;
      r_mem_rdata <= '0;
      r_run_cnt   <= '0;
      r_cancel    <= 1'b0;
    end else begin
      r_fe_ack    <= w_fe_deliver;
      r_fe_rdata  <= w_fe_deliver ? i_bus_rdata : '0;
      r_mem_ack   <= w_mem_done;
      r_mem_rdata <= (w_mem_done && !r_bus_we) ? i_bus_rdata : '0;
      r_cancel    <= r_state == FE_BUSY && !i_bus_ready && (r_cancel || i_flush);
      r_bus_v     <= (w_fe_grant || w_mem_grant) ? 1'b1 : (w_fe_done || w_mem_done) ? 1'b0 : r_bus_v;
      r_run_cnt   <= (!i_fe_req || w_fe_grant) ? 4'd0 :
                     (w_mem_grant && w_fe_el && r_run_cnt != MAX_RUN) ? r_run_cnt + 4'd1 : r_run_cnt;
      if (w_fe_grant) begin
        r_bus_we    <= 1'b0;
        r_bus_size  <= 3'b010;
        r_bus_addr  <= i_fe_addr;
        r_bus_wdata <= '0;
      end else if (w_mem_grant) begin
        r_bus_we    <= i_mem_we;
        r_bus_size  <= i_mem_size;
        r_bus_addr  <= i_mem_addr;
        r_bus_wdata <= i_mem_wdata;
      end
    end
  end
  assign o_bus_v     = r_bus_v;
  assign o_bus_we    = r_bus_we;
  assign o_bus_size  = r_bus_size;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_fe_ack    = r_fe_ack;
  assign o_fe_rdata  = r_fe_rdata;
  assign o_mem_ack   = r_mem_ack;
  assign o_mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level arbitration model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXR = 4;
  logic clk = 0, rst = 1;
  logic fe_req = 0, mem_req = 0, mem_we = 0, flush = 0, bus_ready = 0;
  logic [AW-1:0] fe_addr = '0, mem_addr = '0;
  logic [2:0] mem_size = '0;
  logic [DW-1:0] mem_wdata = '0, bus_rdata = '0;
  logic [DW-1:0] fe_rdata, mem_rdata, bus_wdata;
  logic fe_ack, mem_ack, bus_v, bus_we;
  logic [2:0] bus_size;
  logic [AW-1:0] bus_addr;
  int n_chk = 0, n_pass = 0;
  bit rnd_mode = 0, fe_drop = 0, mem_drop = 0, prev_v = 0;
  int ws = 0, wcnt = 0, am, af, nm, nf;
  logic [DW-1:0] rd_val = '0;
  int gseq[$];
  int sexp[6] = '{0, 0, 0, 0, 1, 0};
  // reference model: who owns the bus, whether the fetch was flushed, data grants fetch sat out
  int owner = 0, streak = 0;
  bit cancel = 0;
  logic e_v = 0, e_we = 0, e_fe_ack = 0, e_mem_ack = 0;
  logic [2:0] e_size = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_fe_rd = '0, e_mem_rd = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR)) dut (
    .i_clk(clk), .i_reset(rst), .i_fe_req(fe_req), .i_fe_addr(fe_addr), .o_fe_rdata(fe_rdata),
    .o_fe_ack(fe_ack), .i_mem_req(mem_req), .i_mem_addr(mem_addr), .i_mem_we(mem_we),
    .i_mem_size(mem_size), .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_ack(mem_ack),
    .i_flush(flush), .o_bus_v(bus_v), .o_bus_we(bus_we), .o_bus_size(bus_size),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic predict();
    logic cur_fe_ack, cur_mem_ack;
    bit fe_el, mem_el, fe_win, mem_win;
    cur_fe_ack = e_fe_ack;
    cur_mem_ack = e_mem_ack;
    e_fe_ack = 0; e_mem_ack = 0; e_fe_rd = '0; e_mem_rd = '0;
    if (rst) begin
      owner = 0; cancel = 0; streak = 0;
      e_v = 0; e_we = 0; e_size = '0; e_addr = '0; e_wdata = '0;
    end else if (owner != 0) begin
      if (owner == 1 && flush) cancel = 1;
      if (bus_ready) begin
        if (owner == 1 && !cancel) begin e_fe_ack = 1; e_fe_rd = bus_rdata; end
        if (owner == 2) begin e_mem_ack = 1; e_mem_rd = e_we ? '0 : bus_rdata; end
        owner = 0; cancel = 0; e_v = 0;
      end
      if (!fe_req) streak = 0;
    end else begin
      mem_el = mem_req && !cur_mem_ack;
      fe_el = fe_req && !cur_fe_ack && !flush;
      fe_win = fe_el && (!mem_el || streak == MAXR);
      mem_win = mem_el && !fe_win;
      if (fe_win) begin owner = 1; e_v = 1; e_we = 0; e_size = 3'b010; e_addr = fe_addr; e_wdata = '0; end
      if (mem_win) begin owner = 2; e_v = 1; e_we = mem_we; e_size = mem_size; e_addr = mem_addr; e_wdata = mem_wdata; end
      if (!fe_req || fe_win) streak = 0;
      else if (mem_win && fe_el && streak < MAXR) streak++;
    end
  endtask

  // memory responder answers after ws wait cycles; then one clock and a full output comparison
  task automatic tick();
    if (bus_v) begin
      bus_ready = (wcnt >= ws);
      wcnt++;
    end else begin
      wcnt = 0;
      bus_ready = rnd_mode && ($urandom_range(3) == 0);
      if (rnd_mode) ws = int'($urandom_range(3));
    end
    bus_rdata = rnd_mode ? $urandom : rd_val;
    predict();
    @(posedge clk);
    #1;
    check("bus_v", 64'(bus_v), 64'(e_v));
    check("bus_we", 64'(bus_we), 64'(e_we));
    check("bus_size", 64'(bus_size), 64'(e_size));
    check("bus_addr", 64'(bus_addr), 64'(e_addr));
    check("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
    check("fe_ack", 64'(fe_ack), 64'(e_fe_ack));
    check("fe_rdata", 64'(fe_rdata), 64'(e_fe_rd));
    check("mem_ack", 64'(mem_ack), 64'(e_mem_ack));
    check("mem_rdata", 64'(mem_rdata), 64'(e_mem_rd));
  endtask

  task automatic retire();
    if (fe_drop) begin fe_req = 0; fe_drop = 0; end
    if (mem_drop) begin mem_req = 0; mem_drop = 0; end
    if (fe_ack) fe_drop = 1;
    if (mem_ack) mem_drop = 1;
  endtask

  initial begin
    rst = 1; tick(); tick(); rst = 0;
    check("rst_v", 64'(bus_v), 64'd0);
    check("rst_ack", 64'(fe_ack | mem_ack), 64'd0);
    // single fetch, zero wait states
    fe_req = 1; fe_addr = 32'h100; ws = 0; rd_val = 32'h13; tick();
    check("t1_v", 64'(bus_v), 64'd1);
    check("t1_addr", 64'(bus_addr), 64'h100);
    tick();
    check("t1_ack", 64'(fe_ack), 64'd1);
    check("t1_rd", 64'(fe_rdata), 64'h13);
    check("t1_v2", 64'(bus_v), 64'd0);
    tick();
    check("t1_noregrant", 64'(bus_v), 64'd0);
    fe_req = 0; tick();
    // data beats fetch, two wait states each
    fe_req = 1; fe_addr = 32'h104; mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_size = 3'd2;
    ws = 2; rd_val = 32'h1111_2222; am = -1; af = -1; nm = 0; nf = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(); retire();
      if (mem_ack) begin nm++; if (am < 0) am = c; end
      if (fe_ack) begin nf++; if (af < 0) af = c; end
    end
    check("pri_mem_cyc", 64'(am), 64'd4);
    check("pri_fe_cyc", 64'(af), 64'd8);
    check("pri_pulses", 64'(nm * 10 + nf), 64'd11);
    // starvation limit: fetch sits out data grants (flushed in each data ack cycle)
    fe_req = 1; fe_addr = 32'h400; mem_req = 1; mem_addr = 32'h5000; ws = 0; rd_val = 32'h5A5A_0000;
    prev_v = 0; fe_drop = 0; mem_drop = 0;
    for (int c = 0; c < 60 && gseq.size() < 6; c++) begin
      tick();
      if (bus_v && !prev_v) gseq.push_back(bus_addr == 32'h400 ? 1 : 0);
      prev_v = bus_v;
      flush = mem_ack;
      if (fe_drop) begin fe_req = 0; fe_drop = 0; end
      if (fe_ack) fe_drop = 1;
    end
    mem_req = 0; fe_req = 0; flush = 0; fe_drop = 0;
    repeat (4) tick();
    check("starve_n", 64'(gseq.size()), 64'd6);
    for (int i = 0; i < 6; i++) check("starve_seq", 64'(i < gseq.size() ? gseq[i] : -1), 64'(sexp[i]));
    // flush while the fetch is on the bus
    fe_req = 1; fe_addr = 32'h180; ws = 2; rd_val = 32'hCAFE_0001; tick();
    check("fl_v1", 64'(bus_v), 64'd1);
    flush = 1; fe_req = 0; tick();
    check("fl_v2", 64'(bus_v), 64'd1);
    flush = 0; tick();
    check("fl_v3", 64'(bus_v), 64'd1);
    tick();
    check("fl_noack", 64'(fe_ack), 64'd0);
    check("fl_rd", 64'(fe_rdata), 64'd0);
    fe_req = 1; fe_addr = 32'h200; ws = 0; tick();
    check("fl_new_addr", 64'(bus_addr), 64'h200);
    tick();
    check("fl_new_ack", 64'(fe_ack), 64'd1);
    check("fl_new_rd", 64'(fe_rdata), 64'hCAFE_0001);
    fe_req = 0; tick();
    // store with three wait states
    mem_req = 1; mem_we = 1; mem_addr = 32'h3004; mem_wdata = 32'hDEAD_BEEF; mem_size = 3'd2;
    ws = 3; rd_val = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("st_v", 64'(bus_v), 64'd1);
      check("st_fields", {bus_addr, bus_wdata}, 64'h0000_3004_DEAD_BEEF);
      check("st_ctl", 64'({bus_we, bus_size}), 64'b1010);
    end
    tick();
    check("st_ack", 64'(mem_ack), 64'd1);
    check("st_rd", 64'(mem_rdata), 64'd0);
    mem_req = 0; mem_we = 0; tick();
    // reset in the middle of a data access
    mem_req = 1; mem_addr = 32'h6000; ws = 3; tick(); tick();
    rst = 1; tick();
    check("rs_v", 64'(bus_v), 64'd0);
    check("rs_fields", {bus_addr, bus_wdata}, 64'd0);
    check("rs_ack", 64'(mem_ack), 64'd0);
    rst = 0; mem_req = 0; fe_req = 1; fe_addr = 32'h240; ws = 0; rd_val = 32'h77; tick();
    check("rs_fv", 64'(bus_v), 64'd1);
    tick();
    check("rs_fack", 64'(fe_ack), 64'd1);
    check("rs_noack", 64'(mem_ack), 64'd0);
    fe_req = 0; tick();
    // randomized traffic with spurious ready, flushes and occasional resets
    rnd_mode = 1; fe_drop = 0; mem_drop = 0;
    for (int c = 0; c < 4000; c++) begin
      retire();
      flush = ($urandom_range(15) == 0);
      if (flush) begin
        fe_drop = 0;
        fe_req = 1'($urandom_range(1));
        fe_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!fe_req && $urandom_range(2) == 0) begin
        fe_req = 1;
        fe_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req && $urandom_range(1) == 0) begin
        mem_req = 1; mem_we = 1'($urandom_range(1)); mem_addr = $urandom;
        mem_size = 3'($urandom_range(7)); mem_wdata = $urandom;
      end
      rst = ($urandom_range(299) == 0);
      if (rst) begin fe_req = 0; mem_req = 0; fe_drop = 0; mem_drop = 0; end
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the fetch stage (instruction reads) and the memory stage (loads and stores). One transaction is outstanding at a time. Data accesses win by default, and a run-length limit prevents fetch starvation. A pipeline flush cancels an in-flight or pending fetch without disturbing the bus protocol. It sits between `fetch`/`memory` and the external memory interface in `top`.

## Interface
Parameters:
- `ADDR_W`, 32, width of the physical memory address.
- `DATA_W`, 32, width of the read and write data.
- `MAX_DATA_RUN`, 4, number of consecutive data grants allowed while fetch is waiting; range 1..15.

Ports:
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `FE_REQ`  in  1  fetch read request; held until `FE_ACK` or dropped on flush.
- `FE_ADDR`  in  ADDR_W  fetch address; stable while `FE_REQ` is high.
- `FE_RDATA`  out  DATA_W  instruction word; valid only while `FE_ACK` is high.
- `FE_ACK`  out  1  one-cycle completion pulse for fetch.
- `MEM_REQ`  in  1  data request; held until `MEM_ACK`.
- `MEM_ADDR`  in  ADDR_W  data address.
- `MEM_WE`  in  1  1 = store, 0 = load.
- `MEM_SIZE`  in  3  access size code, passed through unchanged.
- `MEM_WDATA`  in  DATA_W  store data.
- `MEM_RDATA`  out  DATA_W  load data; valid only while `MEM_ACK` is high.
- `MEM_ACK`  out  1  one-cycle completion pulse for data.
- `FLUSH`  in  1  pipeline flush; cancels fetch only.
- `BUS_V`  out  1  bus transaction valid.
- `BUS_WE`, `BUS_SIZE`(3), `BUS_ADDR`(ADDR_W), `BUS_WDATA`(DATA_W)  out  registered transaction fields.
- `BUS_RDATA`  in  DATA_W  read data; sampled when `BUS_READY` is high.
- `BUS_READY`  in  1  memory completes the current transaction this cycle.

## Operation
- The FSM has three states: `IDLE`, `FE_BUSY`, `MEM_BUSY`.
- Eligibility in `IDLE`:
  - Data is eligible when `MEM_REQ` && !`MEM_ACK`.
  - Fetch is eligible when `FE_REQ` && !`FE_ACK` && !`FLUSH`.
  - The `ACK` terms mask the requester completing this cycle, so it is not re-granted.
- Grant priority in `IDLE`:
  - Data wins, unless fetch is eligible and `run_cnt == MAX_DATA_RUN`; then fetch wins.
  - With neither eligible, stay in `IDLE`.
- On a grant, the winner's address, `WE`, size and write data are latched into the `BUS_*` registers. `BUS_V`=1 from the next cycle.
  - Fetch grants force `BUS_WE`=0, `BUS_SIZE`=3'b010, `BUS_WDATA`=0.
- `run_cnt` (4 bits):
  - Increments on a data grant while fetch is eligible, saturating at `MAX_DATA_RUN`.
  - Clears on a fetch grant, and in any cycle where `FE_REQ`=0.
- In `FE_BUSY` or `MEM_BUSY`, the arbiter waits for `BUS_READY`. On `BUS_READY`=1:
  - It registers `BUS_RDATA` into the owner's `RDATA`.
  - It pulses the owner's `ACK` the next cycle.
  - It drops `BUS_V` and returns to `IDLE`.
- Store `ACK` carries `RDATA`=0.
- Flush:
  - `FLUSH` while in `FE_BUSY` (or on the grant edge) sets `cancel`.
  - The bus transaction still runs to `BUS_READY`. At completion, `FE_ACK` is suppressed, `FE_RDATA` is held at 0, and `cancel` clears.
  - Data transactions ignore `FLUSH`.
- Outputs driven with no `ACK`: `FE_RDATA` and `MEM_RDATA` are 0 whenever their `ACK` is low.

## Timing
- Reset values: state `IDLE`; `BUS_V`, `BUS_WE`, `BUS_SIZE`, `BUS_ADDR`, `BUS_WDATA` = 0; `FE_ACK`, `MEM_ACK`, `FE_RDATA`, `MEM_RDATA` = 0; `run_cnt` = 0; `cancel` = 0.
- `RESET` mid-transaction abandons it. All outputs read 0 in the cycle after the reset edge, and no `ACK` is issued for the abandoned request.
- Minimum latency, with the request seen in `IDLE` at cycle 0:
  - cycle 1: `BUS_V`=1.
  - cycle 1: `BUS_READY`=1 is accepted.
  - cycle 2: `ACK`=1 with data.
  - Each extra wait cycle of `BUS_READY`=0 adds one cycle.
- Back-to-back transactions: a new grant may occur in the `ACK` cycle (cycle 2), giving `BUS_V`=1 in cycle 3. Peak throughput is one transaction per 2 cycles.
- `BUS_*` fields are stable while `BUS_V`=1, and change only on a grant edge.
- Simultaneous `MEM_REQ`, `FE_REQ`, `FLUSH` in `IDLE`: data is granted and the fetch is not considered.
- `FLUSH` while `FE_REQ` is pending in `IDLE`: nothing is granted to fetch that cycle. The fetch may be granted the next cycle if still requested, with the new address.
- `BUS_READY` while in `IDLE` is ignored.

## Test plan
- Single fetch: `FE_REQ`, `FE_ADDR`=0x100, `BUS_READY` high at cycle 1 with `BUS_RDATA`=0x00000013 -> `BUS_V` in cycle 1 only; `FE_ACK` with `FE_RDATA`=0x13 in cycle 2; no re-grant in cycle 2.
- Priority: `FE_REQ` and `MEM_REQ` (load 0x2000) raised together with 2-cycle memory -> data served first, then fetch. Each `ACK` is one pulse, and the `ACK`s are separated by 4 cycles.
- Starvation limit with `MAX_DATA_RUN`=4: `MEM_REQ` re-raised continuously while `FE_REQ` is held -> exactly 4 data grants, then 1 fetch grant, then data again.
- Flush in flight: fetch granted, `FLUSH` at cycle 1, `BUS_READY` at cycle 3 -> `BUS_V` held cycles 1-3, no `FE_ACK`, `FE_RDATA`=0; a subsequent fetch of 0x200 completes normally.
- Store with wait states: `MEM_WE`=1, `MEM_ADDR`=0x3004, `MEM_WDATA`=0xDEADBEEF, `MEM_SIZE`=2, `READY` at cycle 4 -> `BUS_*` stable cycles 1-4; `MEM_ACK` in cycle 5 with `MEM_RDATA`=0.
- Reset mid-transaction: `RESET` at cycle 2 of a busy data access -> all outputs 0 in cycle 3, no `MEM_ACK`; a new fetch after reset is granted with normal latency.
